// File: rtl/aquaflex_pkg.sv
// rtl/aquaflex_pkg.sv - shared states, command codes, route masks and pump phases for the AquaFlex-3b sequencer
package aquaflex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUTE_IN,
    ST_LOAD,
    ST_MIX,
    ST_ROUTE_OUT,
    ST_UNLOAD,
    ST_CLOSE
  } state_t;

  localparam logic [2:0] SRC_B = 3'd0;
  localparam logic [2:0] SRC_C = 3'd1;
  localparam logic [2:0] SRC_D = 3'd2;
  localparam logic [2:0] SRC_E = 3'd3;
  localparam logic [2:0] SRC_F = 3'd4;

  localparam logic [1:0] DST_H = 2'd0;
  localparam logic [1:0] DST_I = 2'd1;
  localparam logic [1:0] DST_J = 2'd2;

  localparam logic [3:0] MASK_NONE  = 4'b0000;
  localparam logic [3:0] SW0_C      = 4'b0110;
  localparam logic [3:0] SW0_D      = 4'b0011;
  localparam logic [3:0] SW0_E      = 4'b1010;
  localparam logic [3:0] SW1_B      = 4'b1100;
  localparam logic [3:0] SW1_F      = 4'b0101;
  localparam logic [3:0] SW1_SHARED = 4'b0110;
  localparam logic [3:0] SW2_H      = 4'b0101;
  localparam logic [3:0] SW2_I      = 4'b1001;
  localparam logic [3:0] SW2_J      = 4'b0011;

  localparam logic [2:0] PHASE_OFF = 3'b000;
  localparam logic [2:0] PHASE_0   = 3'b001;
  localparam logic [2:0] PHASE_1   = 3'b010;
  localparam logic [2:0] PHASE_2   = 3'b100;

  // C, D and E reach PumpA through switch 0 and then the shared switch-1 path
  function automatic logic [3:0] src_sw0(input logic [2:0] src);
    case (src)
      SRC_C:   return SW0_C;
      SRC_D:   return SW0_D;
      SRC_E:   return SW0_E;
      default: return MASK_NONE;
    endcase
  endfunction

  function automatic logic [3:0] src_sw1(input logic [2:0] src);
    case (src)
      SRC_B:                return SW1_B;
      SRC_F:                return SW1_F;
      SRC_C, SRC_D, SRC_E:  return SW1_SHARED;
      default:              return MASK_NONE;
    endcase
  endfunction

  function automatic logic [3:0] dst_sw2(input logic [1:0] dst);
    case (dst)
      DST_H:   return SW2_H;
      DST_I:   return SW2_I;
      DST_J:   return SW2_J;
      default: return MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/aquaflex_pump_driver.sv
// rtl/aquaflex_pump_driver.sv - peristaltic phase sequencer running a programmed number of strokes
module aquaflex_pump_driver
  import aquaflex_pkg::*;
#(
  parameter int STROKE_CYCLES = 8,
  parameter int VOL_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VOL_W-1:0] vol,
  input  logic             abort,
  output logic [2:0]       phase,
  output logic             stroke_done
);

  localparam int PW = $clog2(STROKE_CYCLES + 1);

  logic [PW-1:0]    phase_cnt;
  logic [VOL_W-1:0] strokes_left;
  logic             phase_end;
  logic             last_phase;

  assign phase_end   = (phase != PHASE_OFF) && (phase_cnt == PW'(STROKE_CYCLES - 1));
  assign last_phase  = phase_end && (phase == PHASE_2);
  // Pulses in the final cycle of the final stroke so the FSM leaves its pump state on the same edge the pump stops
  assign stroke_done = last_phase && (strokes_left == VOL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PHASE_OFF;
      phase_cnt    <= '0;
      strokes_left <= '0;
    end else if (abort) begin
      phase     <= PHASE_OFF;
      phase_cnt <= '0;
    end else if (start) begin
      phase        <= PHASE_0;
      phase_cnt    <= '0;
      strokes_left <= vol;
    end else if (phase_end) begin
      phase_cnt <= '0;
      if (last_phase) begin
        strokes_left <= strokes_left - VOL_W'(1);
        phase        <= stroke_done ? PHASE_OFF : PHASE_0;
      end else begin
        phase <= {phase[1:0], 1'b0};
      end
    end else if (phase != PHASE_OFF) begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/aquaflex_3b_sequencer.sv
// rtl/aquaflex_3b_sequencer.sv - run-level controller: route in, load, mix, route out, unload, close
module aquaflex_3b_sequencer
  import aquaflex_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STROKE_CYCLES = 8,
  parameter int VOL_W         = 8,
  parameter int MIX_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  input  logic [VOL_W-1:0] cmd_vol,
  input  logic [MIX_W-1:0] cmd_mix,
  input  logic             abort,
  output logic [3:0]       sw0_open,
  output logic [3:0]       sw1_open,
  output logic [3:0]       sw2_open,
  output logic [2:0]       pump_a,
  output logic [2:0]       pump_c,
  output logic             mixer_en,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic             err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (SW > MIX_W) ? SW : MIX_W;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [2:0]       src_q, src_n;
  logic [1:0]       dst_q, dst_n;
  logic [VOL_W-1:0] vol_q;
  logic [MIX_W-1:0] mix_q;
  logic             aborted_q, aborted_n;
  logic             latch, legal, abort_hit;
  logic             start_a, start_c, a_done, c_done;
  logic             done_n, err_n;
  logic [3:0]       sw0_n, sw1_n, sw2_n;

  assign legal     = (cmd_src <= SRC_F) && (cmd_dst <= DST_J) && (cmd_vol != '0);
  assign abort_hit = abort && (state != ST_IDLE) && (state != ST_CLOSE);

  always_comb begin
    state_n   = state;
    timer_n   = (timer != '0) ? timer - TW'(1) : '0;
    aborted_n = aborted_q;
    latch     = 1'b0;
    start_a   = 1'b0;
    start_c   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        if (legal) begin
          state_n   = ST_ROUTE_IN;
          timer_n   = SETTLE_LOAD;
          latch     = 1'b1;
          aborted_n = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end
      ST_ROUTE_IN: if (timer == '0) begin
        state_n = ST_LOAD;
        start_a = 1'b1;
      end
      ST_LOAD: if (a_done) begin
        if (mix_q != '0) begin
          state_n = ST_MIX;
          timer_n = TW'(mix_q) - TW'(1);
        end else begin
          state_n = ST_ROUTE_OUT;
          timer_n = SETTLE_LOAD;
        end
      end
      ST_MIX: if (timer == '0) begin
        state_n = ST_ROUTE_OUT;
        timer_n = SETTLE_LOAD;
      end
      ST_ROUTE_OUT: if (timer == '0) begin
        state_n = ST_UNLOAD;
        start_c = 1'b1;
      end
      ST_UNLOAD: if (c_done) begin
        state_n = ST_CLOSE;
        timer_n = SETTLE_LOAD;
      end
      ST_CLOSE: if (timer == '0) begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_n   = ST_CLOSE;
      timer_n   = SETTLE_LOAD;
      start_a   = 1'b0;
      start_c   = 1'b0;
      aborted_n = 1'b1;
    end
  end

  // Masks are decoded from the next state so they register on the same edge the state changes
  assign src_n = latch ? cmd_src : src_q;
  assign dst_n = latch ? cmd_dst : dst_q;

  always_comb begin
    sw0_n = MASK_NONE;
    sw1_n = MASK_NONE;
    sw2_n = MASK_NONE;
    case (state_n)
      ST_ROUTE_IN, ST_LOAD: begin
        sw0_n = src_sw0(src_n);
        sw1_n = src_sw1(src_n);
      end
      ST_ROUTE_OUT, ST_UNLOAD: sw2_n = dst_sw2(dst_n);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      vol_q        <= '0;
      mix_q        <= '0;
      aborted_q    <= 1'b0;
      sw0_open     <= MASK_NONE;
      sw1_open     <= MASK_NONE;
      sw2_open     <= MASK_NONE;
      mixer_en     <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      src_q        <= src_n;
      dst_q        <= dst_n;
      aborted_q    <= aborted_n;
      if (latch) begin
        vol_q <= cmd_vol;
        mix_q <= cmd_mix;
      end
      sw0_open     <= sw0_n;
      sw1_open     <= sw1_n;
      sw2_open     <= sw2_n;
      mixer_en     <= (state_n == ST_MIX);
      busy         <= (state_n != ST_IDLE);
      cmd_ready    <= (state_n == ST_IDLE);
      done         <= done_n;
      done_aborted <= done_n && aborted_q;
      err          <= err_n;
    end
  end

  aquaflex_pump_driver #(
    .STROKE_CYCLES(STROKE_CYCLES),
    .VOL_W        (VOL_W)
  ) u_pump_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .vol        (vol_q),
    .abort      (abort_hit),
    .phase      (pump_a),
    .stroke_done(a_done)
  );

  aquaflex_pump_driver #(
    .STROKE_CYCLES(STROKE_CYCLES),
    .VOL_W        (VOL_W)
  ) u_pump_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_c),
    .vol        (vol_q),
    .abort      (abort_hit),
    .phase      (pump_c),
    .stroke_done(c_done)
  );

endmodule

// File: tb/tb_aquaflex_3b_sequencer.sv
// tb/tb_aquaflex_3b_sequencer.sv - bench for aquaflex_3b_sequencer against a per-cycle run trace model
module tb_aquaflex_3b_sequencer;

  localparam int S  = 2;
  localparam int K  = 1;
  localparam int VW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_src;
  logic [1:0]    cmd_dst;
  logic [VW-1:0] cmd_vol;
  logic [MW-1:0] cmd_mix;
  logic          abort;
  logic [3:0]    sw0_open, sw1_open, sw2_open;
  logic [2:0]    pump_a, pump_c;
  logic          mixer_en, busy, done, done_aborted, err;

  int errors = 0;
  int checks = 0;
  logic [22:0] exp_q[$];
  logic [22:0] idle_rec;
  int nxt_src, nxt_dst, nxt_vol, nxt_mix;

  aquaflex_3b_sequencer #(
    .SETTLE_CYCLES(S),
    .STROKE_CYCLES(K),
    .VOL_W        (VW),
    .MIX_W        (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_vol     (cmd_vol),
    .cmd_mix     (cmd_mix),
    .abort       (abort),
    .sw0_open    (sw0_open),
    .sw1_open    (sw1_open),
    .sw2_open    (sw2_open),
    .pump_a      (pump_a),
    .pump_c      (pump_c),
    .mixer_en    (mixer_en),
    .busy        (busy),
    .done        (done),
    .done_aborted(done_aborted),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] ports(input int a, input int b);
    logic [3:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] m_sw0(input int src);
    case (src)
      1:       return ports(2, 1);
      2:       return ports(0, 1);
      3:       return ports(3, 1);
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] m_sw1(input int src);
    case (src)
      0:       return ports(3, 2);
      4:       return ports(0, 2);
      default: return ports(1, 2);
    endcase
  endfunction

  function automatic logic [3:0] m_sw2(input int dst);
    case (dst)
      0:       return ports(0, 2);
      1:       return ports(0, 3);
      default: return ports(0, 1);
    endcase
  endfunction

  function automatic logic [22:0] rec(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                      input logic [2:0] pa, input logic [2:0] pc, input logic mx,
                                      input logic bz, input logic dn, input logic da, input logic rd,
                                      input logic er);
    return {s0, s1, s2, pa, pc, mx, bz, dn, da, rd, er};
  endfunction

  function automatic logic [22:0] observed();
    return {sw0_open, sw1_open, sw2_open, pump_a, pump_c, mixer_en, busy, done, done_aborted, cmd_ready, err};
  endfunction

  task automatic check(input string tag, input int cyc, input logic [22:0] e);
    logic [22:0] o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b (sw0 sw1 sw2 pa pc mix busy done dab rdy err)",
             tag, cyc, o, e);
    end
  endtask

  task automatic push(input int n, input logic [22:0] r);
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  // Expected outputs for cycles 1..done, built phase by phase from the run description
  task automatic build(input int src, input int dst, input int vol, input int mix, input int abort_at);
    logic [3:0] m0, m1, m2;
    logic       aborted;
    m0 = m_sw0(src);
    m1 = m_sw1(src);
    m2 = m_sw2(dst);
    aborted = 1'b0;
    exp_q.delete();
    push(S, rec(m0, m1, 4'b0, 3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int v = 0; v < vol; v++)
      for (int p = 0; p < 3; p++)
        push(K, rec(m0, m1, 4'b0, 3'(1 << p), 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(mix, rec(4'b0, 4'b0, 4'b0, 3'b0, 3'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(S, rec(4'b0, 4'b0, m2, 3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int v = 0; v < vol; v++)
      for (int p = 0; p < 3; p++)
        push(K, rec(4'b0, 4'b0, m2, 3'b0, 3'(1 << p), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    if (abort_at > 0 && abort_at <= exp_q.size()) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      aborted = 1'b1;
    end
    push(S, rec(4'b0, 4'b0, 4'b0, 3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push(1, rec(4'b0, 4'b0, 4'b0, 3'b0, 3'b0, 1'b0, 1'b0, 1'b1, aborted, 1'b1, 1'b0));
  endtask

  // Entered at a falling edge with the DUT ready; returns at the falling edge of the done cycle
  task automatic run_cmd(input string tag, input int src, input int dst, input int vol, input int mix,
                         input int abort_at, input int stop_at, input bit keep);
    build(src, dst, vol, mix, abort_at);
    cmd_src   = 3'(src);
    cmd_dst   = 2'(dst);
    cmd_vol   = VW'(vol);
    cmd_mix   = MW'(mix);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= exp_q.size(); i++) begin
      if (i > 1) @(negedge clk);
      check(tag, i, exp_q[i-1]);
      if (i == 1) begin
        if (keep) begin
          cmd_src = 3'(nxt_src);
          cmd_dst = 2'(nxt_dst);
          cmd_vol = VW'(nxt_vol);
          cmd_mix = MW'(nxt_mix);
        end else begin
          cmd_valid = 1'b0;
          cmd_src   = 3'($urandom);
          cmd_dst   = 2'($urandom);
          cmd_vol   = VW'($urandom);
          cmd_mix   = MW'($urandom);
        end
      end
      abort = (i == abort_at);
      if (i == stop_at) break;
    end
  endtask

  task automatic reject(input string tag, input int src, input int dst, input int vol);
    cmd_src   = 3'(src);
    cmd_dst   = 2'(dst);
    cmd_vol   = VW'(vol);
    cmd_mix   = MW'($urandom_range(0, 5));
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(tag, 1, rec(4'b0, 4'b0, 4'b0, 3'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cmd_valid = 1'b0;
    @(negedge clk);
    check(tag, 2, idle_rec);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, i, idle_rec);
    end
  endtask

  initial begin
    int src, dst, vol, mix, ab, len, stop;
    idle_rec  = rec(4'b0, 4'b0, 4'b0, 3'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_vol   = '0;
    cmd_mix   = '0;
    abort     = 1'b0;
    @(negedge clk);
    check("reset", 0, idle_rec);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("post_reset", 2);

    run_cmd("c_to_i", 1, 1, 2, 3, 0, 0, 1'b0);
    idle_cycles("after_c_to_i", 1);
    run_cmd("b_to_j_nomix", 0, 2, 1, 0, 0, 0, 1'b0);
    idle_cycles("after_b_to_j", 1);

    reject("bad_src", 6, 0, 1);
    reject("bad_dst", 0, 3, 1);
    reject("zero_vol", 2, 1, 0);
    reject("bad_src7", 7, 1, 3);

    abort = 1'b1;
    idle_cycles("abort_in_idle", 3);
    abort = 1'b0;

    run_cmd("abort_load2", 3, 0, 3, 2, S + 2, 0, 1'b0);
    idle_cycles("after_abort", 1);

    nxt_src = 4; nxt_dst = 1; nxt_vol = 2; nxt_mix = 0;
    run_cmd("b2b_first", 2, 0, 1, 1, 0, 0, 1'b1);
    run_cmd("b2b_second", nxt_src, nxt_dst, nxt_vol, nxt_mix, 0, 0, 1'b0);
    idle_cycles("after_b2b", 1);

    for (int n = 0; n < 14; n++) begin
      src = $urandom_range(0, 4);
      dst = $urandom_range(0, 2);
      vol = $urandom_range(1, 4);
      mix = $urandom_range(0, 4);
      len = 3 * S + 6 * K * vol + mix;
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - S) : 0;
      run_cmd("random_run", src, dst, vol, mix, ab, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles("random_gap", $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) reject("random_reject", 5, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    vol  = 2;
    mix  = 1;
    stop = 2 * S + 3 * K * vol + mix + 2;
    run_cmd("pre_reset_run", 1, 0, vol, mix, 0, stop, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", 0, idle_rec);
    @(negedge clk);
    check("reset_held", 0, idle_rec);
    rst_n = 1'b1;
    idle_cycles("after_mid_reset", 3 * S + 6 * K * vol + mix);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
